logic_unit_seq: RTL
===================

# logic_unit_seq

Parametrised, registered successor to the combinational 32-bit AND element: a WIDTH-bit logic/shift unit with valid/ready handshakes on input and output. Bitwise ops complete in one cycle. Shifts run iteratively, one bit per cycle, under a small FSM. It sits between the operand registers and the writeback stage of the lab datapath, and is the building block for the later multi-cycle ALU experiments.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not to be overridden.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  operation select:
  - 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ANDN (A & ~B)
  - 5 SLL, 6 SRL, 7 SRA
- A  in  WIDTH  first operand; the value shifted by shift ops.
- B  in  WIDTH  second operand; for shifts, the amount is B[SHW-1:0] and upper bits are ignored.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts result.
- res  out  WIDTH  registered result.
- zero  out  1  registered; high when res == 0, valid with out_valid.

## Operation
- One clock and one reset: clk rising edge, rst_n asynchronous and active-low.
- Reset values: state IDLE, res 0, zero 0, out_valid 0, shift counter 0, so in_ready = 1.
- FSM has three states: IDLE, SHIFT and DONE.
- IDLE: in_ready = 1. On an edge with in_valid = 1, capture op/A/B (the accept), then:
  - bitwise op (0–4): res ← f(A,B); zero ← (f == 0); go to DONE.
  - shift with amount k = 0: res ← A; zero ← (A == 0); go to DONE.
  - shift with k > 0: res ← A; cnt ← k; go to SHIFT.
- SHIFT: in_ready = 0 and out_valid = 0. On each edge:
  - shift res by 1: SLL fills 0 at the LSB; SRL fills 0 at the MSB; SRA replicates res[WIDTH-1].
  - cnt ← cnt − 1.
  - When cnt == 1 before the edge, go to DONE and set zero from the final shifted value.
- DONE: out_valid = 1; res and zero are held stable while out_ready = 0.
  - On an edge with out_ready = 1, go to IDLE. res keeps its value; out_valid drops.
- in_valid is ignored outside IDLE. The source must hold its values until the in_ready/in_valid handshake.
- No simultaneous accept and drain: in_ready is 0 in DONE, so a new input is taken at the earliest one cycle after the drain edge.
- Arithmetic rules:
  - All ops are width-preserving; there are no carries and no overflow.
  - A shift amount of WIDTH−1 is legal. Amounts ≥ WIDTH cannot be expressed.
- Reset asserted mid-SHIFT or in DONE: immediate return to reset values; the partial result is discarded.

## Timing
- in_ready and out_valid are decoded combinationally from the state register. res and zero are registered outputs.
- Accept at edge N:
  - bitwise op or k = 0: out_valid high after edge N (latency 1).
  - shift k > 0: out_valid high after edge N+k (latency k+1 cycles from accept to valid).
- Throughput with out_ready tied high:
  - one bitwise op every 2 cycles.
  - one shift every k+2 cycles.
- Backpressure: out_valid stays high indefinitely while out_ready = 0.
- out_ready asserted while out_valid = 0 has no effect.

## Test plan
- Reset:
  - assert rst_n = 0 asynchronously mid-SHIFT (SLL, A = 1, B = 20, after 5 cycles) → res = 0, out_valid = 0, in_ready = 1 immediately, without waiting for an edge.
- Bitwise ops, out_ready = 1, WIDTH = 32:
  - AND A = 0000000F, B = 00000005 → res 00000005, zero 0, out_valid one cycle after accept.
  - AND A = FFFFFFFF, B = 0 → res 0, zero 1.
  - NOR A = 0, B = 0 → res FFFFFFFF.
  - ANDN A = FF, B = 0F → res F0.
- Shifts:
  - SRA A = 80000000, B = 31 → res FFFFFFFF after exactly 31 cycles in SHIFT.
  - SRL same operands → res 00000001.
  - SLL A = 1, B = 0 → res 1 with 1-cycle latency.
- Backpressure:
  - complete XOR A = AAAAAAAA, B = 55555555 with out_ready = 0 for 10 cycles → res FFFFFFFF held, in_ready = 0 throughout.
  - in_valid pulses with other operands during those 10 cycles are ignored.
- Back-to-back: out_ready = 1 with in_valid held high and operands changed after each accept → accepts occur every 2 cycles and results match in order with no drops.
- Parameter sweep: WIDTH = 8; SRA A = 80, B = 7 → res FF; SLL A = 01, B = 7 → res 80, zero 0.

Source files
------------

// File: rtl/logic_unit_seq.sv
// Registered WIDTH-bit logic/shift unit with valid/ready handshakes on both sides.
// Bitwise ops finish in one cycle; shifts step one bit per cycle under a small FSM.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero
);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("logic_unit_seq: WIDTH must be a power of two and at least 2");
    end

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOR  = 3'd3,
        OP_ANDN = 3'd4,
        OP_SLL  = 3'd5,
        OP_SRL  = 3'd6,
        OP_SRA  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   res_q;
    logic               zero_q;
    logic [SHW-1:0]     cnt_q;

    logic [WIDTH-1:0]   bitwise_res;
    logic [WIDTH-1:0]   shifted;
    logic               is_shift;
    logic [SHW-1:0]     shamt;

    assign is_shift = op[2] & (op[1] | op[0]);
    assign shamt    = B[SHW-1:0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        bitwise_res = '0;
        case (op_e'(op))
            OP_AND:  bitwise_res = A & B;
            OP_OR:   bitwise_res = A | B;
            OP_XOR:  bitwise_res = A ^ B;
            OP_NOR:  bitwise_res = ~(A | B);
            OP_ANDN: bitwise_res = A & ~B;
            default: bitwise_res = '0;
        endcase
    end

    always_comb begin
        shifted = res_q;
        case (op_q)
            OP_SLL:  shifted = {res_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, res_q[WIDTH-1:1]};
            OP_SRA:  shifted = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
            default: shifted = res_q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            res_q   <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q <= op_e'(op);
                        if (!is_shift) begin
                            res_q   <= bitwise_res;
                            zero_q  <= (bitwise_res == '0);
                            state_q <= ST_DONE;
                        end else if (shamt == '0) begin
                            res_q   <= A;
                            zero_q  <= (A == '0);
                            state_q <= ST_DONE;
                        end else begin
                            res_q   <= A;
                            cnt_q   <= shamt;
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    res_q <= shifted;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        zero_q  <= (shifted == '0);
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign res       = res_q;
    assign zero      = zero_q;

endmodule
